// File: rtl/ctrl_pipe_unit.sv
// Pipelined RV32I control unit: ID decode, ID/EX, EX/MEM and MEM/WB control registers, EX redirect.
// Define CTRL_JUMP_EN to decode JAL/JALR; otherwise both opcodes are treated as illegal.
module ctrl_pipe_unit #(
    parameter int ALUCTRL_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [6:0]           Op,
    input  logic [2:0]           funct3,
    input  logic [6:0]           funct7,
    input  logic                 StallE,
    input  logic                 FlushE,
    input  logic                 ZeroE,
    input  logic                 LtE,
    input  logic                 LtuE,
    output logic [2:0]           ImmSrcD,
    output logic                 IllegalD,
    output logic [ALUCTRL_W-1:0] ALUControlE,
    output logic                 ALUSrcE,
    output logic                 JalrE,
    output logic                 PCSrcE,
    output logic                 RegWriteM,
    output logic                 MemWriteM,
    output logic [1:0]           ResultSrcM,
    output logic                 RegWriteW,
    output logic [1:0]           ResultSrcW
);

    localparam logic [3:0] ALU_ADD  = 4'd0,  ALU_SUB  = 4'd1,  ALU_AND = 4'd2, ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4,  ALU_SLT  = 4'd5,  ALU_SLTU = 4'd6, ALU_SLL = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8,  ALU_SRA  = 4'd9,  ALU_PASSB = 4'd10;
    localparam logic [2:0] IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_J = 3'd3, IMM_U = 3'd4;

    function automatic logic [3:0] alu_from_f3(input logic is_r, input logic [2:0] f3, input logic f7b5);
        case (f3)
            3'b000:  return (is_r && f7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return f7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    // Only funct7[5] distinguishes SUB/SRA; the rest of the field is don't-care.
    logic unused_funct7;
    assign unused_funct7 = ^{funct7[6], funct7[4:0]};

    logic       reg_write_d, alu_src_d, mem_write_d, branch_d;
    logic [1:0] result_src_d;
    logic [2:0] funct3_d;
    logic [3:0] alu_op_d;
    logic [ALUCTRL_W-1:0] alu_ctrl_d;
`ifdef CTRL_JUMP_EN
    logic       jump_d, jalr_d;
`endif

    always_comb begin
        reg_write_d  = 1'b0;
        alu_src_d    = 1'b0;
        mem_write_d  = 1'b0;
        branch_d     = 1'b0;
        result_src_d = 2'b00;
        funct3_d     = funct3;
        alu_op_d     = ALU_ADD;
        ImmSrcD      = IMM_I;
        IllegalD     = 1'b0;
`ifdef CTRL_JUMP_EN
        jump_d       = 1'b0;
        jalr_d       = 1'b0;
`endif
        case (Op)
            7'b0110011: begin
                reg_write_d = 1'b1;
                alu_op_d    = alu_from_f3(1'b1, funct3, funct7[5]);
            end
            7'b0010011: begin
                reg_write_d = 1'b1;
                alu_src_d   = 1'b1;
                alu_op_d    = alu_from_f3(1'b0, funct3, funct7[5]);
            end
            7'b0000011: begin
                reg_write_d  = 1'b1;
                alu_src_d    = 1'b1;
                result_src_d = 2'b01;
            end
            7'b0100011: begin
                alu_src_d   = 1'b1;
                mem_write_d = 1'b1;
                ImmSrcD     = IMM_S;
            end
            7'b1100011: begin
                branch_d = 1'b1;
                alu_op_d = ALU_SUB;
                ImmSrcD  = IMM_B;
            end
            7'b0110111: begin
                reg_write_d = 1'b1;
                alu_src_d   = 1'b1;
                alu_op_d    = ALU_PASSB;
                ImmSrcD     = IMM_U;
            end
`ifdef CTRL_JUMP_EN
            7'b1101111: begin
                reg_write_d  = 1'b1;
                result_src_d = 2'b10;
                jump_d       = 1'b1;
                ImmSrcD      = IMM_J;
            end
            7'b1100111: begin
                reg_write_d  = 1'b1;
                alu_src_d    = 1'b1;
                result_src_d = 2'b10;
                jump_d       = 1'b1;
                jalr_d       = 1'b1;
            end
`endif
            default: begin
                IllegalD = 1'b1;
                funct3_d = 3'b000;
            end
        endcase
    end

    // Zero-extend the 4-bit ALU code to the configured output width.
    genvar gi;
    generate
        for (gi = 0; gi < ALUCTRL_W; gi++) begin : g_alu_ext
            if (gi < 4) begin : g_code
                assign alu_ctrl_d[gi] = alu_op_d[gi];
            end else begin : g_pad
                assign alu_ctrl_d[gi] = 1'b0;
            end
        end
    endgenerate

    logic                 ex_reg_write_reg, ex_alu_src_reg, ex_mem_write_reg, ex_branch_reg;
    logic [1:0]           ex_result_src_reg;
    logic [2:0]           ex_funct3_reg;
    logic [ALUCTRL_W-1:0] ex_alu_ctrl_reg;
    logic                 ex_reg_write_next, ex_alu_src_next, ex_mem_write_next, ex_branch_next;
    logic [1:0]           ex_result_src_next;
    logic [2:0]           ex_funct3_next;
    logic [ALUCTRL_W-1:0] ex_alu_ctrl_next;
    logic                 mem_reg_write_reg, mem_mem_write_reg, wb_reg_write_reg;
    logic [1:0]           mem_result_src_reg, wb_result_src_reg;
    logic                 mem_reg_write_next, mem_mem_write_next;
    logic [1:0]           mem_result_src_next;

    // Flush beats stall; a stalled EX sends a bubble downstream rather than a duplicate.
    always_comb begin
        ex_reg_write_next  = reg_write_d;
        ex_alu_src_next    = alu_src_d;
        ex_mem_write_next  = mem_write_d;
        ex_branch_next     = branch_d;
        ex_result_src_next = result_src_d;
        ex_funct3_next     = funct3_d;
        ex_alu_ctrl_next   = alu_ctrl_d;
        if (FlushE) begin
            ex_reg_write_next  = 1'b0;
            ex_alu_src_next    = 1'b0;
            ex_mem_write_next  = 1'b0;
            ex_branch_next     = 1'b0;
            ex_result_src_next = 2'b00;
            ex_funct3_next     = 3'b000;
            ex_alu_ctrl_next   = '0;
        end else if (StallE) begin
            ex_reg_write_next  = ex_reg_write_reg;
            ex_alu_src_next    = ex_alu_src_reg;
            ex_mem_write_next  = ex_mem_write_reg;
            ex_branch_next     = ex_branch_reg;
            ex_result_src_next = ex_result_src_reg;
            ex_funct3_next     = ex_funct3_reg;
            ex_alu_ctrl_next   = ex_alu_ctrl_reg;
        end
        mem_reg_write_next  = StallE ? 1'b0  : ex_reg_write_reg;
        mem_mem_write_next  = StallE ? 1'b0  : ex_mem_write_reg;
        mem_result_src_next = StallE ? 2'b00 : ex_result_src_reg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_reg_write_reg   <= 1'b0;
            ex_alu_src_reg     <= 1'b0;
            ex_mem_write_reg   <= 1'b0;
            ex_branch_reg      <= 1'b0;
            ex_result_src_reg  <= 2'b00;
            ex_funct3_reg      <= 3'b000;
            ex_alu_ctrl_reg    <= '0;
            mem_reg_write_reg  <= 1'b0;
            mem_mem_write_reg  <= 1'b0;
            mem_result_src_reg <= 2'b00;
            wb_reg_write_reg   <= 1'b0;
            wb_result_src_reg  <= 2'b00;
        end else begin
            ex_reg_write_reg   <= ex_reg_write_next;
            ex_alu_src_reg     <= ex_alu_src_next;
            ex_mem_write_reg   <= ex_mem_write_next;
            ex_branch_reg      <= ex_branch_next;
            ex_result_src_reg  <= ex_result_src_next;
            ex_funct3_reg      <= ex_funct3_next;
            ex_alu_ctrl_reg    <= ex_alu_ctrl_next;
            mem_reg_write_reg  <= mem_reg_write_next;
            mem_mem_write_reg  <= mem_mem_write_next;
            mem_result_src_reg <= mem_result_src_next;
            wb_reg_write_reg   <= mem_reg_write_reg;
            wb_result_src_reg  <= mem_result_src_reg;
        end
    end

    logic branch_cond;
    always_comb begin
        case (ex_funct3_reg)
            3'b000:  branch_cond = ZeroE;
            3'b001:  branch_cond = !ZeroE;
            3'b100:  branch_cond = LtE;
            3'b101:  branch_cond = !LtE;
            3'b110:  branch_cond = LtuE;
            3'b111:  branch_cond = !LtuE;
            default: branch_cond = 1'b0;
        endcase
    end

`ifdef CTRL_JUMP_EN
    logic ex_jump_reg, ex_jalr_reg, ex_jump_next, ex_jalr_next;
    always_comb begin
        ex_jump_next = jump_d;
        ex_jalr_next = jalr_d;
        if (FlushE) begin
            ex_jump_next = 1'b0;
            ex_jalr_next = 1'b0;
        end else if (StallE) begin
            ex_jump_next = ex_jump_reg;
            ex_jalr_next = ex_jalr_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_jump_reg <= 1'b0;
            ex_jalr_reg <= 1'b0;
        end else begin
            ex_jump_reg <= ex_jump_next;
            ex_jalr_reg <= ex_jalr_next;
        end
    end

    assign JalrE  = ex_jalr_reg;
    assign PCSrcE = (ex_branch_reg & branch_cond) | ex_jump_reg;
`else
    assign JalrE  = 1'b0;
    assign PCSrcE = ex_branch_reg & branch_cond;
`endif

    assign ALUControlE = ex_alu_ctrl_reg;
    assign ALUSrcE     = ex_alu_src_reg;
    assign RegWriteM   = mem_reg_write_reg;
    assign MemWriteM   = mem_mem_write_reg;
    assign ResultSrcM  = mem_result_src_reg;
    assign RegWriteW   = wb_reg_write_reg;
    assign ResultSrcW  = wb_result_src_reg;

endmodule
